two_port_mem_pipe: RTL and testbench
====================================

Name: two_port_mem_pipe

Overview:
Simple dual-port RAM on a single clock, with one write port (A) and one read port (B). It extends the basic two-port RAM with per-byte write enables, a configurable read pipeline with a valid flag, and defined read/write collision behaviour. It can optionally zero the whole memory after reset. It sits under the NN datapath as weight/activation storage where consumers need known contents and a registered valid.

Parameters:
BIT_LENGTH, 64, data width in bits; must be a multiple of 8
DEPTH, 16, number of words; need not be a power of 2
READ_LATENCY, 1, cycles from read issue to doutb_valid; legal range 1..4
COLLISION, "write_first", same-address same-cycle policy: "write_first" or "read_first"
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = contents undefined after reset
MODE, "block", RAM style attribute applied to the storage array

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  port A enable
wea  in  1  write strobe; acts only when ena=1
bea  in  BIT_LENGTH/8  byte-lane write enables; bit i covers dina[8i+7:8i]
addra  in  $clog2(DEPTH)  write address
dina  in  BIT_LENGTH  write data
enb  in  1  read request
addrb  in  $clog2(DEPTH)  read address
doutb  out  BIT_LENGTH  read data
doutb_valid  out  1  doutb carries the response to a request issued READ_LATENCY cycles earlier
init_busy  out  1  clear sequence in progress; both ports are ignored while high

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values while rst=1: doutb=0, doutb_valid=0, read valid pipeline flushed.
  - CLEAR_ON_RESET=1: init_busy=1 and clear address counter=0.
  - CLEAR_ON_RESET=0: init_busy=0.
- FSM states: CLEAR and READY.
  - rst=1: go to CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: each cycle with rst=0, write all-zero to word clr_addr and increment clr_addr.
  - CLEAR exit: the cycle that writes word DEPTH-1 moves to READY.
  - Timing: after rst falls, init_busy stays high for exactly DEPTH cycles.
  - rst asserted during CLEAR restarts the clear from address 0.
- While init_busy=1: port A writes are dropped, enb is ignored, no doutb_valid is generated.
- Write (READY, ena&wea): for each i with bea[i]=1, word[addra] lane i <= dina lane i. Other lanes keep their value. bea=0 means no change.
- Read (READY, enb): request issued at cycle t.
  - doutb and doutb_valid=1 appear at cycle t+READY_LATENCY... i.e. t+READ_LATENCY.
  - doutb_valid is high exactly one cycle per request.
  - Back-to-back requests give back-to-back responses, with full throughput of one read per cycle.
  - doutb holds its last value when doutb_valid=0.
- Collision (write and read to the same address in the same cycle):
  - write_first: response is the merged word: new bytes in enabled lanes, old bytes elsewhere.
  - read_first: response is the pre-write word.
  - A write to an address with a read already in the pipeline does not alter that in-flight response.
- Out-of-range addresses (addr >= DEPTH when DEPTH is not a power of 2):
  - Writes are ignored.
  - Reads return 0 with doutb_valid=1 at normal latency.
- No wrap-around of addresses; the counter only wraps in CLEAR, where it stops at DEPTH-1.
- Storage is exactly DEPTH words.
- Elaboration checks:
  - BIT_LENGTH%8 != 0 is a fatal error.
  - READ_LATENCY outside 1..4 is a fatal error.
  - An illegal COLLISION string is a fatal error.

Test Plan:
- Reset/clear: DEPTH=16, CLEAR_ON_RESET=1; pulse rst 2 cycles -> init_busy high 16 cycles after rst falls. Then reading all 16 addresses gives 0. A write issued during busy is lost.
- Latency/throughput: READ_LATENCY=3; write addr k = k*0x1111 for k=0..7, then 8 consecutive reads -> doutb_valid high 8 consecutive cycles starting 3 cycles after the first enb, with values in order.
- Byte enables: write 0x0123456789ABCDEF with bea=0xFF, then dina=0xFFFFFFFFFFFFFFFF with bea=0x0F to addr 5 -> read returns 0x01234567FFFFFFFF.
- Collision: addr 3 holds 0xAA..AA; same-cycle write 0x55..55 (bea all ones) and read of addr 3 -> write_first build returns 0x55..55; read_first build returns 0xAA..AA; next read returns 0x55..55 in both.
- Non-power-of-2: DEPTH=10; write addr 12 then read addr 12 -> doutb=0, valid=1; addr 0..9 unaffected.
- Reset mid-clear: assert rst at clear cycle 7 -> counter restarts at 0, init_busy lasts a full DEPTH cycles after release, and in-flight doutb_valid is cleared.

Source files
------------

// File: rtl/two_port_mem_pipe.sv
// Simple dual-port RAM: byte-masked write port A, pipelined read port B with a
// registered valid, defined same-address collision policy and optional post-reset zeroing.
module two_port_mem_pipe #(
    parameter int    BIT_LENGTH     = 64,
    parameter int    DEPTH          = 16,
    parameter int    READ_LATENCY   = 1,
    parameter string COLLISION      = "write_first",
    parameter int    CLEAR_ON_RESET = 1,
    parameter string MODE           = "block",
    localparam int   AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int   NB             = BIT_LENGTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [NB-1:0]         bea,
    input  logic [AW-1:0]         addra,
    input  logic [BIT_LENGTH-1:0] dina,
    input  logic                  enb,
    input  logic [AW-1:0]         addrb,
    output logic [BIT_LENGTH-1:0] doutb,
    output logic                  doutb_valid,
    output logic                  init_busy
);

    if (BIT_LENGTH <= 0 || (BIT_LENGTH % 8) != 0) begin : g_bad_width
        $fatal(1, "two_port_mem_pipe: BIT_LENGTH must be a positive multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "two_port_mem_pipe: READ_LATENCY must be in 1..4");
    end
    if (COLLISION != "write_first" && COLLISION != "read_first") begin : g_bad_collision
        $fatal(1, "two_port_mem_pipe: COLLISION must be write_first or read_first");
    end

    localparam bit            WRITE_FIRST = (COLLISION == "write_first");
    localparam logic [AW:0]   DEPTH_W     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          clr_we;
    logic          ready;
    logic          wr_en;
    logic          rd_en;
    logic          addra_ok;
    logic          addrb_ok;

    (* ram_style = MODE *) logic [BIT_LENGTH-1:0] mem_q [DEPTH];

    logic [BIT_LENGTH-1:0] rd_old;
    logic [BIT_LENGTH-1:0] rd_merged;
    logic [BIT_LENGTH-1:0] rd_data;

    logic [READ_LATENCY:1] vld_pipe_q;
    logic [BIT_LENGTH-1:0] dat_pipe_q [READ_LATENCY:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear walks 0..DEPTH-1 once; the cycle that zeroes the last word hands over to READY.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = ~rst;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = S_READY;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == S_CLEAR);
    assign ready     = (state_q == S_READY) && !rst;
    assign addra_ok  = ({1'b0, addra} < DEPTH_W);
    assign addrb_ok  = ({1'b0, addrb} < DEPTH_W);
    assign wr_en     = ready && ena && wea && addra_ok;
    assign rd_en     = ready && enb;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bea[i]) mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    // Read data is captured at issue, so later writes never disturb an in-flight response.
    always_comb begin
        rd_old = '0;
        if (addrb_ok) rd_old = mem_q[addrb];
        rd_merged = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (bea[i]) rd_merged[8*i +: 8] = dina[8*i +: 8];
        end
        rd_data = rd_old;
        if (WRITE_FIRST && wr_en && (addra == addrb)) rd_data = rd_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int k = 1; k <= READ_LATENCY; k++) dat_pipe_q[k] <= '0;
        end else begin
            vld_pipe_q[1] <= rd_en;
            if (rd_en) dat_pipe_q[1] <= rd_data;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                if (vld_pipe_q[k-1]) dat_pipe_q[k] <= dat_pipe_q[k-1];
            end
        end
    end

    assign doutb       = dat_pipe_q[READ_LATENCY];
    assign doutb_valid = vld_pipe_q[READ_LATENCY];

endmodule

// File: tb/tb_two_port_mem_pipe.sv
// Drives two builds (16 words / latency 3 / write_first and 10 words / latency 1 /
// read_first) with shared stimulus and checks each against a per-cycle scoreboard.
module tb_two_port_mem_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ena, wea, enb;
    logic [7:0]  bea;
    logic [3:0]  addra, addrb;
    logic [63:0] dina;

    logic [63:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1;

    two_port_mem_pipe #(
        .BIT_LENGTH(64), .DEPTH(16), .READ_LATENCY(3), .COLLISION("write_first"),
        .CLEAR_ON_RESET(1), .MODE("block")
    ) u_wf (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout0), .doutb_valid(vld0), .init_busy(busy0)
    );

    two_port_mem_pipe #(
        .BIT_LENGTH(64), .DEPTH(10), .READ_LATENCY(1), .COLLISION("read_first"),
        .CLEAR_ON_RESET(1), .MODE("block")
    ) u_rf (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout1), .doutb_valid(vld1), .init_busy(busy1)
    );

    // Reference model: word arrays, a busy countdown and a table of responses keyed by cycle.
    int          dep [2] = '{16, 10};
    int          lat [2] = '{3, 1};
    bit          wfst[2] = '{1'b1, 1'b0};
    logic [63:0] mm  [2][16];
    bit          ev  [2][0:4095];
    logic [63:0] ed  [2][0:4095];
    logic [63:0] last[2];
    int          busy_left[2];
    int          cyc   = 0;
    int          nchk  = 0;
    int          npass = 0;
    int          nfail = 0;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input int d);
        logic [63:0] r;
        if (rst) begin
            busy_left[d] = dep[d];
            for (int k = 0; k < 16; k++) mm[d][k] = '0;
            for (int k = 0; k < 5; k++) ev[d][cyc+k] = 1'b0;
            last[d] = '0;
        end else if (busy_left[d] > 0) begin
            busy_left[d]--;
        end else begin
            if (enb) begin
                if (int'(addrb) >= dep[d]) r = '0;
                else if (wfst[d] && ena && wea && addra == addrb) r = merge(mm[d][addrb], dina, bea);
                else r = mm[d][addrb];
                ev[d][cyc+lat[d]-1] = 1'b1;
                ed[d][cyc+lat[d]-1] = r;
            end
            if (ena && wea && int'(addra) < dep[d]) mm[d][addra] = merge(mm[d][addra], dina, bea);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic w, input logic [7:0] be,
                        input logic [3:0] aa, input logic [63:0] di, input logic eb,
                        input logic [3:0] ab);
        rst = r; ena = e; wea = w; bea = be; addra = aa; dina = di; enb = eb; addrb = ab;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) if (ev[d][cyc]) last[d] = ed[d][cyc];
        chk("wf_valid", 64'(vld0),  64'(ev[0][cyc]));
        chk("wf_doutb", dout0,      last[0]);
        chk("wf_busy",  64'(busy0), 64'(busy_left[0] > 0));
        chk("rf_valid", 64'(vld1),  64'(ev[1][cyc]));
        chk("rf_doutb", dout1,      last[1]);
        chk("rf_busy",  64'(busy1), 64'(busy_left[1] > 0));
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step(0, 1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
                 {$urandom, $urandom}, 1'($urandom), 4'($urandom));
    endtask

    initial begin
        rst = 1'b1; ena = 0; wea = 0; enb = 0; bea = '0; addra = '0; addrb = '0; dina = '0;

        // Two-cycle reset, then writes and reads offered while the clear runs.
        step(1, 0, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
        step(1, 0, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 8'hFF, 4'd2, 64'hDEAD_BEEF_CAFE_F00D, 1, 4'd2);

        for (int k = 0; k < 16; k++) step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(k));
        idle(4);

        // Fill then stream eight back-to-back reads.
        for (int k = 0; k < 8; k++) step(0, 1, 1, 8'hFF, 4'(k), 64'(k * 32'h1111), 0, 4'd0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(k));
        idle(4);

        // Byte-lane merge.
        step(0, 1, 1, 8'hFF, 4'd5, 64'h0123_4567_89AB_CDEF, 0, 4'd0);
        step(0, 1, 1, 8'h0F, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'd0);
        step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd5);
        step(0, 1, 1, 8'h00, 4'd5, 64'h0, 1, 4'd5);
        idle(4);

        // Same-address collision, partial and full masks.
        step(0, 1, 1, 8'hFF, 4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 0, 4'd0);
        step(0, 1, 1, 8'hFF, 4'd3, 64'h5555_5555_5555_5555, 1, 4'd3);
        step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd3);
        step(0, 1, 1, 8'h3C, 4'd3, 64'h1234_5678_9ABC_DEF0, 1, 4'd3);
        step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd3);
        idle(4);

        // Address 12 lies beyond the 10-word build.
        step(0, 1, 1, 8'hFF, 4'd12, 64'hC0DE_C0DE_C0DE_C0DE, 0, 4'd0);
        step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd12);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(k));
        idle(4);

        rand_steps(300);

        // Reset with reads in flight, then reset again seven cycles into the clear.
        step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd1);
        step(1, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'd2);
        for (int i = 0; i < 7; i++) step(0, 1, 1, 8'hFF, 4'(i), 64'hFFFF_0000_FFFF_0000, 1, 4'(i));
        step(1, 0, 0, 8'h00, 4'd0, 64'd0, 0, 4'd0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 8'hFF, 4'(i), 64'h1111_2222_3333_4444, 1, 4'(i));
        for (int k = 0; k < 16; k++) step(0, 0, 0, 8'h00, 4'd0, 64'd0, 1, 4'(k));
        rand_steps(150);
        idle(5);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
